// File: rtl/wb_irq_ctrl_pkg.sv
// rtl/wb_irq_ctrl_pkg.sv - shared register map, claim-ID width and claim helper for wb_irq_ctrl
package wb_irq_ctrl_pkg;

  // Word index decoded from ADR_I[4:2]; byte offset = index * 4
  typedef enum logic [2:0] {
    REG_PENDING  = 3'd0,  // 0x00 R, W1C on edge sources
    REG_ENABLE   = 3'd1,  // 0x04 RW
    REG_MODE     = 3'd2,  // 0x08 RW, 1 = edge, 0 = level
    REG_POLARITY = 3'd3,  // 0x0C RW, 1 = active-low source
    REG_STATUS   = 3'd4,  // 0x10 RO, PENDING & ENABLE
    REG_RAW      = 3'd5,  // 0x14 RO, synchronised polarity-corrected lines
    REG_CLAIM    = 3'd6,  // 0x18 CLAIM when enabled, otherwise reserved
    REG_RSVD     = 3'd7   // 0x1C reserved
  } reg_addr_e;

  localparam logic MODE_LEVEL = 1'b0;
  localparam logic MODE_EDGE  = 1'b1;
  localparam logic POL_HIGH   = 1'b0;
  localparam logic POL_LOW    = 1'b1;

  // Claim IDs are source index + 1, so 0 can mean "nothing pending"
  localparam int CLAIM_W = 6;

  function automatic logic [CLAIM_W-1:0] lowest_set_id(input logic [31:0] v);
    lowest_set_id = '0;
    // Scan downwards so the lowest set index is the last one written
    for (int i = 31; i >= 0; i--) begin
      if (v[i]) lowest_set_id = CLAIM_W'(i + 1);
    end
  endfunction

endpackage

// File: rtl/wb_irq_ctrl_if.sv
// rtl/wb_irq_ctrl_if.sv - Wishbone classic bus bundle for the interrupt controller
// Signals: cyc, stb, we, adr[31:0], dat_w[31:0], sel[3:0] (master -> slave);
//          dat_r[31:0], ack (slave -> master)
interface wb_irq_ctrl_if;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [31:0] adr;
  logic [31:0] dat_w;
  logic [3:0]  sel;
  logic [31:0] dat_r;
  logic        ack;

  modport master (output cyc, stb, we, adr, dat_w, sel, input dat_r, ack);
  modport slave  (input cyc, stb, we, adr, dat_w, sel, output dat_r, ack);
endinterface

// File: rtl/irq_src_cond.sv
// rtl/irq_src_cond.sv - per-source IRQ synchroniser, polarity correction and edge detect
// Ports: clk_i, rst_ni (async active-low), src_i raw line, pol_i (1 = active-low),
//        s_o conditioned level, edge_o one-cycle rising pulse of s_o
module irq_src_cond #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic src_i,
  input  logic pol_i,
  output logic s_o,
  output logic edge_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  assign s_o    = sync_q[SYNC_STAGES-1] ^ pol_i;
  // prev follows s every cycle, so mode changes on a steady line never fake an edge
  assign edge_o = s_o & ~prev_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], src_i};
      prev_q <= s_o;
    end
  end

endmodule

// File: rtl/wb_irq_ctrl.sv
// rtl/wb_irq_ctrl.sv - Wishbone interrupt controller: pending/enable/mode/polarity registers driving irq_o
// Optional feature macro: IRQC_CLAIM_EN (adds CLAIM register at 0x18)
// Ports: CLK_I clock, RST_I async active-low reset, wb Wishbone slave bundle,
//        irq_src_i raw peripheral lines, irq_o registered PENDING & ENABLE to the core
module wb_irq_ctrl
  import wb_irq_ctrl_pkg::*;
#(
  parameter int NUM_SRC     = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic               CLK_I,
  input  logic               RST_I,
  wb_irq_ctrl_if.slave       wb,
  input  logic [NUM_SRC-1:0] irq_src_i,
  output logic [NUM_SRC-1:0] irq_o
);

  logic [NUM_SRC-1:0] s, edge_p;
  logic [NUM_SRC-1:0] pend_q, en_q, mode_q, pol_q, irq_q;
  logic [NUM_SRC-1:0] pend_d, en_d, mode_d, pol_d;
  logic [NUM_SRC-1:0] status, wmask, wdata, w1c, claim_clr;
  logic [31:0]        wmask32, rdata, dat_q;
  logic               ack_q, req, wr, rd;
  reg_addr_e          reg_sel;
  logic               unused_adr;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    irq_src_cond #(.SYNC_STAGES(SYNC_STAGES)) u_cond (
      .clk_i  (CLK_I),
      .rst_ni (RST_I),
      .src_i  (irq_src_i[g]),
      .pol_i  (pol_q[g]),
      .s_o    (s[g]),
      .edge_o (edge_p[g])
    );
  end

  assign unused_adr = ^{wb.adr[31:5], wb.adr[1:0]};
  // Holding ACK_O blocks a second request, giving one access per ACK even with STB held
  assign req     = wb.cyc & wb.stb & ~ack_q;
  assign wr      = req & wb.we;
  assign rd      = req & ~wb.we;
  assign reg_sel = reg_addr_e'(wb.adr[4:2]);
  assign wmask32 = {{8{wb.sel[3]}}, {8{wb.sel[2]}}, {8{wb.sel[1]}}, {8{wb.sel[0]}}};
  assign wmask   = NUM_SRC'(wmask32);
  assign wdata   = NUM_SRC'(wb.dat_w);
  assign status  = pend_q & en_q;

`ifdef IRQC_CLAIM_EN
  logic [CLAIM_W-1:0] claim_id;
  assign claim_id  = lowest_set_id(32'(status));
  // Claiming only retires edge sources; a level source stays pending while its line is active
  assign claim_clr = (rd && reg_sel == REG_CLAIM && claim_id != '0)
                   ? ((NUM_SRC'(1) << (claim_id - CLAIM_W'(1))) & mode_q) : '0;
`else
  assign claim_clr = '0;
`endif

  always_comb begin
    rdata = '0;
    case (reg_sel)
      REG_PENDING:  rdata = 32'(pend_q);
      REG_ENABLE:   rdata = 32'(en_q);
      REG_MODE:     rdata = 32'(mode_q);
      REG_POLARITY: rdata = 32'(pol_q);
      REG_STATUS:   rdata = 32'(status);
      REG_RAW:      rdata = 32'(s);
`ifdef IRQC_CLAIM_EN
      REG_CLAIM:    rdata = 32'(claim_id);
`endif
      default:      rdata = '0;
    endcase
  end

  always_comb begin
    w1c    = (wr && reg_sel == REG_PENDING) ? (wdata & wmask & mode_q) : '0;
    // Edge: a new edge wins over a same-cycle clear. Level: follow s directly.
    pend_d = (mode_q & (edge_p | (pend_q & ~w1c & ~claim_clr))) | (~mode_q & s);
    en_d   = (wr && reg_sel == REG_ENABLE)   ? ((en_q   & ~wmask) | (wdata & wmask)) : en_q;
    mode_d = (wr && reg_sel == REG_MODE)     ? ((mode_q & ~wmask) | (wdata & wmask)) : mode_q;
    pol_d  = (wr && reg_sel == REG_POLARITY) ? ((pol_q  & ~wmask) | (wdata & wmask)) : pol_q;
  end

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      pend_q <= '0;
      en_q   <= '0;
      mode_q <= '0;
      pol_q  <= '0;
      irq_q  <= '0;
      ack_q  <= 1'b0;
      dat_q  <= '0;
    end else begin
      pend_q <= pend_d;
      en_q   <= en_d;
      mode_q <= mode_d;
      pol_q  <= pol_d;
      irq_q  <= pend_q & en_q;
      ack_q  <= req;
      if (rd) dat_q <= rdata;
    end
  end

  assign wb.ack   = ack_q;
  assign wb.dat_r = dat_q;
  assign irq_o    = irq_q;

endmodule

// File: tb/tb_wb_irq_ctrl.sv
// tb/tb_wb_irq_ctrl.sv - directed self-checking bench for wb_irq_ctrl
module tb_wb_irq_ctrl;
  import wb_irq_ctrl_pkg::*;

  localparam int NUM_SRC = 8;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [NUM_SRC-1:0] irq_src;
  logic [NUM_SRC-1:0] irq_o;
  int                 n_cmp = 0;
  int                 n_err = 0;
  logic [31:0]        q;

  wb_irq_ctrl_if wb();

  wb_irq_ctrl #(.NUM_SRC(NUM_SRC), .SYNC_STAGES(2)) dut (
    .CLK_I     (clk),
    .RST_I     (rst_n),
    .wb        (wb.slave),
    .irq_src_i (irq_src),
    .irq_o     (irq_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic wb_access(input logic we, input logic [2:0] r, input logic [31:0] d,
                           input logic [3:0] sel, output logic [31:0] rq);
    logic got;
    @(posedge clk); #1;
    wb.cyc = 1'b1; wb.stb = 1'b1; wb.we = we;
    wb.adr = {27'd0, r, 2'b00}; wb.dat_w = d; wb.sel = sel;
    got = 1'b0;
    for (int i = 0; i < 4 && !got; i++) begin
      @(posedge clk); #1;
      if (wb.ack) got = 1'b1;
    end
    wb.cyc = 1'b0; wb.stb = 1'b0; wb.we = 1'b0;
    if (!got) check("ack_timeout", 32'(got), 32'd1);
    rq = wb.dat_r;
  endtask

  task automatic wr(input logic [2:0] r, input logic [31:0] d);
    logic [31:0] dummy;
    wb_access(1'b1, r, d, 4'hF, dummy);
  endtask

  task automatic rd(input logic [2:0] r, output logic [31:0] rq);
    wb_access(1'b0, r, 32'd0, 4'hF, rq);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; irq_src = '0;
    wb.cyc = 1'b0; wb.stb = 1'b0; wb.we = 1'b0;
    wb.adr = '0; wb.dat_w = '0; wb.sel = '0;
    cycles(3);
    check("rst_irq", 32'(irq_o), 32'd0);
    check("rst_ack", 32'(wb.ack), 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // 1: reset in the middle of operation
    wr(REG_MODE, 32'h05);
    wr(REG_ENABLE, 32'h05);
    @(posedge clk); #1; irq_src = 8'h05;
    cycles(3); irq_src = '0;
    cycles(6);
    rd(REG_PENDING, q);
    check("t1_pend", q, 32'h05);
    check("t1_irq", 32'(irq_o), 32'h05);
    @(negedge clk); rst_n = 1'b0; #1;
    check("t1_rst_irq", 32'(irq_o), 32'd0);
    check("t1_rst_ack", 32'(wb.ack), 32'd0);
    check("t1_rst_dat", wb.dat_r, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    for (int r = 0; r < 6; r++) begin
      rd(3'(r), q);
      check($sformatf("t1_reg%0d", r), q, 32'd0);
    end

    // 2: level mode latency, W1C has no effect while the line is high
    wr(REG_ENABLE, 32'h01);
    @(posedge clk); #1; irq_src[0] = 1'b1;
    cycles(3);
    check("t2_edge3", 32'(irq_o), 32'd0);
    cycles(1);
    check("t2_edge4", 32'(irq_o), 32'h01);
    wr(REG_PENDING, 32'h01);
    cycles(2);
    check("t2_w1c_lvl", 32'(irq_o), 32'h01);
    irq_src[0] = 1'b0;
    cycles(5);
    check("t2_low", 32'(irq_o), 32'd0);

    // 3: edge mode latch, W1C timing, set beats clear on the same edge
    wr(REG_MODE, 32'h04);
    wr(REG_ENABLE, 32'h04);
    @(posedge clk); #1; irq_src[2] = 1'b1;
    cycles(3); irq_src[2] = 1'b0;
    cycles(6);
    check("t3_irq_held", 32'(irq_o), 32'h04);
    rd(REG_PENDING, q);
    check("t3_pend", q, 32'h04);
    wr(REG_PENDING, 32'h04);
    check("t3_w1c_e1", 32'(irq_o), 32'h04);
    cycles(1);
    check("t3_w1c_e2", 32'(irq_o), 32'd0);
    @(posedge clk); #1; irq_src[2] = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    wb.cyc = 1'b1; wb.stb = 1'b1; wb.we = 1'b1;
    wb.adr = {27'd0, REG_PENDING, 2'b00}; wb.dat_w = 32'h04; wb.sel = 4'hF;
    @(posedge clk); #1;
    check("t3_race_ack", 32'(wb.ack), 32'd1);
    wb.cyc = 1'b0; wb.stb = 1'b0; wb.we = 1'b0;
    rd(REG_PENDING, q);
    check("t3_race_pend", q, 32'h04);
    irq_src[2] = 1'b0;
    wr(REG_PENDING, 32'h04);
    rd(REG_PENDING, q);
    check("t3_cleared", q, 32'd0);

    // 4: polarity and byte lanes, reserved read
    wr(REG_POLARITY, 32'h02);
    cycles(4);
    rd(REG_RAW, q);
    check("t4_raw", q, 32'h02);
    wb_access(1'b1, REG_ENABLE, 32'hFFFF_FF03, 4'b0001, q);
    rd(REG_ENABLE, q);
    check("t4_sel", q, 32'h03);
    cycles(2);
    check("t4_pol_irq", 32'(irq_o), 32'h02);
    rd(REG_RSVD, q);
    check("t4_rsvd", q, 32'd0);
    cycles(1);
    check("t4_ack_drop", 32'(wb.ack), 32'd0);
    wr(REG_POLARITY, 32'h00);
    cycles(5);
    check("t4_pol_off", 32'(irq_o), 32'd0);

    // 5: STB held three cycles
    @(posedge clk); #1;
    wb.cyc = 1'b1; wb.stb = 1'b1; wb.we = 1'b1;
    wb.adr = {27'd0, REG_ENABLE, 2'b00}; wb.dat_w = 32'h5A; wb.sel = 4'hF;
    check("t5_ack0", 32'(wb.ack), 32'd0);
    cycles(1);
    check("t5_ack1", 32'(wb.ack), 32'd1);
    cycles(1);
    check("t5_ack2", 32'(wb.ack), 32'd0);
    cycles(1);
    check("t5_ack3", 32'(wb.ack), 32'd1);
    wb.cyc = 1'b0; wb.stb = 1'b0; wb.we = 1'b0;
    rd(REG_ENABLE, q);
    check("t5_en", q, 32'h5A);

    // 6: claim sequence, or reserved behaviour at 0x18
`ifdef IRQC_CLAIM_EN
    wr(REG_MODE, 32'h22);
    wr(REG_ENABLE, 32'h22);
    @(posedge clk); #1; irq_src = 8'h22;
    cycles(3); irq_src = '0;
    cycles(6);
    rd(REG_CLAIM, q);
    check("t6_claim1", q, 32'd2);
    rd(REG_CLAIM, q);
    check("t6_claim2", q, 32'd6);
    rd(REG_CLAIM, q);
    check("t6_claim3", q, 32'd0);
    rd(REG_PENDING, q);
    check("t6_pend", q, 32'd0);
`else
    rd(REG_CLAIM, q);
    check("t6_rsvd18", q, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
